// File: rtl/ahfp_pkg.sv
// ahfp_pkg: shared constants and types for the ahfp arithmetic datapath
// (multiplier and divider).
//   FP_BIAS, EXP_MAX, FP_QNAN : binary32 numeric constants
//   *_BIT / *_MSB / *_LSB     : field positions inside a binary32 word
//   state_t                   : FSM state encoding of the multi-cycle units
//   DIV_ITERS                 : quotient bits produced by the divider
package ahfp_pkg;

  localparam int          FP_BIAS  = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  // One quotient bit per iteration: 24 mantissa bits plus one extra so a
  // quotient in [0.5, 1) still yields a full 24-bit significand.
  localparam int DIV_ITERS = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ahfp_div_mant.sv
// ahfp_div_mant: radix-2 restoring mantissa divider, one quotient bit per
// clock while enabled.
//   clk, reset : clock, synchronous active-high reset (clears rem and q)
//   load       : initialise rem = {0, ma}, q = 0
//   en         : perform one restoring step this cycle
//   ma, mb     : 24-bit significands with hidden bit; mb must stay stable
//                for the whole iteration
//   q          : 25-bit quotient register, q = floor(ma * 2^24 / mb) after
//                25 steps
module ahfp_div_mant (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic [24:0] q
);

  logic [24:0] rem;
  logic [24:0] divisor;
  logic        ge;
  logic [24:0] diff;

  assign divisor = {1'b0, mb};

  // After a successful subtract rem < mb < 2^24, so the left shift never
  // loses a set bit out of the 25-bit remainder.
  always_comb begin
    ge   = (rem >= divisor);
    diff = ge ? (rem - divisor) : rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      q   <= '0;
    end else if (load) begin
      rem <= {1'b0, ma};
      q   <= '0;
    end else if (en) begin
      rem <= diff << 1;
      q   <= {q[23:0], ge};
    end
  end

endmodule

// File: rtl/ahfp_div_multi.sv
// ahfp_div_multi: multi-cycle binary32 divider, result = dataa / datab.
// Flush-to-zero, truncating, never produces denormals.
//   clk, reset : clock, synchronous active-high reset (aborts any operation)
//   start      : request, only honoured in IDLE
//   dataa      : dividend, captured when start is accepted
//   datab      : divisor, captured when start is accepted
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse, result valid from this cycle
//   result     : quotient, held until the next NORM edge or reset
module ahfp_div_multi
  import ahfp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t             state;
  state_t             state_nxt;
  logic        [4:0]  cnt;

  logic               s_in;
  logic        [7:0]  ea_in;
  logic        [7:0]  eb_in;
  logic               is_special;
  logic        [31:0] special_val;

  logic               s_r;
  logic        [7:0]  ea_r;
  logic        [7:0]  eb_r;
  logic        [23:0] mb_r;
  logic               special_r;
  logic        [31:0] special_val_r;

  logic               accept;
  logic               mant_load;
  logic               mant_en;
  logic        [24:0] q;
  logic signed [9:0]  e_norm;
  logic        [22:0] mant_norm;

  // Exponent saturation: overflow goes to signed infinity, underflow flushes
  // to signed zero (no denormals are ever produced).
  function automatic logic [31:0] pack_quotient(input logic              s,
                                                input logic signed [9:0] e,
                                                input logic [22:0]       mant);
    if (e >= 10'sd255)
      return {s, 8'hFF, 23'h0};
    else if (e <= 10'sd0)
      return {s, 31'h0};
    else
      return {s, e[7:0], mant};
  endfunction

  // Operand decode and special-case classification, in priority order.
  always_comb begin
    s_in        = dataa[SIGN_BIT] ^ datab[SIGN_BIT];
    ea_in       = dataa[EXP_MSB:EXP_LSB];
    eb_in       = datab[EXP_MSB:EXP_LSB];
    is_special  = 1'b1;
    special_val = FP_QNAN;
    if (ea_in == 8'(EXP_MAX) || eb_in == 8'(EXP_MAX) ||
        (ea_in == 8'h00 && eb_in == 8'h00)) begin
      special_val = FP_QNAN;
    end else if (eb_in == 8'h00) begin
      special_val = {s_in, 8'hFF, 23'h0};
    end else if (ea_in == 8'h00) begin
      special_val = {s_in, 31'h0};
    end else begin
      is_special  = 1'b0;
      special_val = '0;
    end
  end

  assign accept    = (state == IDLE) && start;
  assign mant_load = accept && !is_special;
  assign mant_en   = (state == DIV);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = is_special ? NORM : DIV;
      DIV:  if (cnt == 5'd0) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= 5'(DIV_ITERS - 1);
    end else if (state == DIV && cnt != 5'd0) begin
      cnt <= cnt - 5'd1;
    end
  end

  // Operand capture is data only; it is fully rewritten on every accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      s_r           <= s_in;
      ea_r          <= ea_in;
      eb_r          <= eb_in;
      mb_r          <= {1'b1, datab[MANT_MSB:0]};
      special_r     <= is_special;
      special_val_r <= special_val;
    end
  end

  ahfp_div_mant u_mant (
    .clk   (clk),
    .reset (reset),
    .load  (mant_load),
    .en    (mant_en),
    .ma    ({1'b1, dataa[MANT_MSB:0]}),
    .mb    (mb_r),
    .q     (q)
  );

  // q[24] set means the quotient is in [1, 2); otherwise it is in [0.5, 1)
  // and the significand is one bit lower with the exponent reduced by one.
  always_comb begin
    if (q[24]) begin
      mant_norm = q[23:1];
      e_norm    = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + 10'sd127;
    end else begin
      mant_norm = q[22:0];
      e_norm    = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + 10'sd126;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      result <= '0;
    else if (state == NORM)
      result <= special_r ? special_val_r : pack_quotient(s_r, e_norm, mant_norm);
  end

endmodule

// File: tb/tb_ahfp_div_multi.sv
module tb_ahfp_div_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahfp_div_multi dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Issue one request and report latency (edges after accept until done is
  // seen), the result in the done cycle, and the done pulse width.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output int width);
    wait_idle();
    dataa = a;
    datab = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = -1;
    res   = 32'hDEAD_BEEF;
    width = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
    if (lat > 0) begin
      for (int k = 0; k < 5 && done; k++) begin
        width++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dataa = '0;
    datab = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    logic [31:0] a [4] = '{32'h4100_0000, 32'h3F80_0000, 32'h4128_0000, 32'hC040_0000};
    logic [31:0] b [4] = '{32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000};
    logic [31:0] x [4] = '{32'h4080_0000, 32'h3EAA_AAAA, 32'h4060_0000, 32'hBF80_0000};
    int lat, width;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      do_op(a[i], b[i], lat, res, width);
      checks++; if (res !== x[i]) begin errors++; $display("FAIL normal_%0d_result: got %h expected %h", i, res, x[i]); end
      checks++; if (lat !== 26) begin errors++; $display("FAIL normal_%0d_latency: got %0d expected 26", i, lat); end
      checks++; if (width !== 1) begin errors++; $display("FAIL normal_%0d_done_width: got %0d expected 1", i, width); end
    end
  endtask

  task automatic test_special();
    logic [31:0] a [4] = '{32'h0000_0000, 32'hC000_0000, 32'h0000_0000, 32'h7F80_0000};
    logic [31:0] b [4] = '{32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000};
    logic [31:0] x [4] = '{32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000};
    int lat, width;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      do_op(a[i], b[i], lat, res, width);
      checks++; if (res !== x[i]) begin errors++; $display("FAIL special_%0d_result: got %h expected %h", i, res, x[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL special_%0d_latency: got %0d expected 1", i, lat); end
      checks++; if (width !== 1) begin errors++; $display("FAIL special_%0d_done_width: got %0d expected 1", i, width); end
    end
  endtask

  task automatic test_range();
    int lat, width;
    logic [31:0] res;
    do_op(32'h7F00_0000, 32'h3F00_0000, lat, res, width);
    checks++; if (res !== 32'h7F80_0000) begin errors++; $display("FAIL overflow_result: got %h expected 7f800000", res); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL overflow_latency: got %0d expected 26", lat); end
    do_op(32'h0080_0000, 32'h4000_0000, lat, res, width);
    checks++; if (res !== 32'h0000_0000) begin errors++; $display("FAIL underflow_result: got %h expected 00000000", res); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL underflow_latency: got %0d expected 26", lat); end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    logic [31:0] res = 32'hDEAD_BEEF;
    wait_idle();
    dataa = 32'h4100_0000;
    datab = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b expected 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_after_accept: got %b expected 0", done); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
    end
    dataa = 32'h3F80_0000;
    datab = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dataa = '0;
    datab = '0;
    for (int k = 6; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
    checks++; if (res !== 32'h4080_0000) begin errors++; $display("FAIL ignore_start_result: got %h expected 40800000", res); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL ignore_start_latency: got %0d expected 26", lat); end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    logic [31:0] r1 = 32'hDEAD_BEEF;
    logic [31:0] r2 = 32'hDEAD_BEEF;
    wait_idle();
    dataa = 32'h4100_0000;
    datab = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) begin
          first = k;
          r1 = result;
        end else if (second < 0) begin
          second = k;
          r2 = result;
        end
      end
      if (k == 27) dataa = 32'h4128_0000;
      if (k == 27) datab = 32'h4040_0000;
    end
    start = 1'b0;
    checks++; if (first !== 26) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 26", first); end
    checks++; if (second - first !== 28) begin errors++; $display("FAIL b2b_spacing: got %0d expected 28", second - first); end
    checks++; if (r1 !== 32'h4080_0000) begin errors++; $display("FAIL b2b_first_result: got %h expected 40800000", r1); end
    checks++; if (r2 !== 32'h4060_0000) begin errors++; $display("FAIL b2b_second_result: got %h expected 40600000", r2); end
  endtask

  task automatic test_reset_mid();
    int lat, width;
    int done_seen = 0;
    logic [31:0] res;
    do_op(32'h4100_0000, 32'h4000_0000, lat, res, width);
    wait_idle();
    dataa = 32'h4040_0000;
    datab = 32'h3F80_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h expected 00000000", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", done_seen); end
    do_op(32'h4040_0000, 32'h3F80_0000, lat, res, width);
    checks++; if (res !== 32'h4040_0000) begin errors++; $display("FAIL after_reset_result: got %h expected 40400000", res); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL after_reset_latency: got %0d expected 26", lat); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
